// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared types and default widths for the conv2d address sequencer.
//   state_t         : sequencer FSM states
//   ADDR_WIDTH_DEF  : default byte-address width of image memory
//   DIM_WIDTH_DEF   : default width of dimension fields and counters
package conv2d_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int DIM_WIDTH_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_READ,
      ST_WRITE,
      ST_FIN
   } state_t;

endpackage

// File: rtl/conv2d_win_counter.sv
// conv2d_win_counter: 2-D position counter, x innermost.
//   clk, resetn   : clock, async active-low reset
//   clr           : synchronous return to (0,0)
//   inc           : advance one position; wraps to (0,0) after (lim_x,lim_y)
//   lim_x, lim_y  : last valid index in each dimension (inclusive)
//   x, y          : current position
//   x_wrap        : x is at lim_x
//   last          : position is (lim_x,lim_y)
module conv2d_win_counter
   import conv2d_pkg::*;
#(
   parameter int W = DIM_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] lim_x,
   input  logic [W-1:0] lim_y,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         x_wrap,
   output logic         last
);

   assign x_wrap = (x == lim_x);
   assign last   = x_wrap && (y == lim_y);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (inc) begin
         if (x_wrap) begin
            x <= '0;
            y <= last ? '0 : y + W'(1);
         end else begin
            x <= x + W'(1);
         end
      end
   end

endmodule

// File: rtl/conv2d_seq.sv
// conv2d_seq: address sequencer for the conv2d accelerator. Latches a job
// configuration on start, then for every valid output position issues one
// read per kernel tap followed by one result write.
//   clk, resetn              : clock, async active-low reset
//   start, abort             : job launch (IDLE only) / synchronous cancel
//   img_w, img_h, k_w, k_h   : image and kernel dimensions
//   in_base, out_base        : image and result base byte addresses
//   rd_addr/first/last/valid, rd_ready : tap read request channel
//   wr_addr/valid, wr_ready  : result write request channel
//   busy, done, err          : job status
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CHECK | validate latched config, prime address pointers
// ST_READ  | issuing tap reads for the current window
// ST_WRITE | issuing the result write for the current window
// ST_FIN   | one-cycle done pulse
module conv2d_seq
   import conv2d_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DIM_WIDTH-1:0]  img_w,
   input  logic [DIM_WIDTH-1:0]  img_h,
   input  logic [DIM_WIDTH-1:0]  k_w,
   input  logic [DIM_WIDTH-1:0]  k_h,
   input  logic [ADDR_WIDTH-1:0] in_base,
   input  logic [ADDR_WIDTH-1:0] out_base,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_first,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t state;

   logic [DIM_WIDTH-1:0]  img_w_q, img_h_q, k_w_q, k_h_q;
   logic [ADDR_WIDTH-1:0] in_base_q, out_base_q;

   // line_base: first pixel of the current output row's top image row
   // win_base : top-left pixel of the current window
   // row_ptr  : first pixel of the current kernel row in the window
   logic [ADDR_WIDTH-1:0] line_base, win_base, row_ptr;
   logic [ADDR_WIDTH-1:0] img_w_a, next_row, next_line, next_win;

   logic [DIM_WIDTH-1:0]  kx, ky, ox, oy;
   logic [DIM_WIDTH-1:0]  k_lim_x, k_lim_y, o_lim_x, o_lim_y;
   logic                  kx_wrap, k_last, ox_wrap, o_last;
   logic                  cfg_bad, rd_fire, wr_fire, cnt_clr;
   logic                  unused_pos;

   assign img_w_a   = ADDR_WIDTH'(img_w_q);
   assign next_row  = row_ptr + img_w_a;
   assign next_line = line_base + img_w_a;
   assign next_win  = win_base + ADDR_WIDTH'(1);

   // Zero-sized kernels and kernels larger than the image also cover the
   // empty-image case, so no separate img_w/img_h test is needed.
   assign cfg_bad = (k_w_q == '0) || (k_h_q == '0) ||
                    (k_w_q > img_w_q) || (k_h_q > img_h_q);

   assign k_lim_x = k_w_q - DIM_WIDTH'(1);
   assign k_lim_y = k_h_q - DIM_WIDTH'(1);
   assign o_lim_x = img_w_q - k_w_q;
   assign o_lim_y = img_h_q - k_h_q;

   assign rd_fire = (state == ST_READ)  && rd_ready && !abort;
   assign wr_fire = (state == ST_WRITE) && wr_ready && !abort;
   assign cnt_clr = (state == ST_CHECK);

   assign rd_first = rd_valid && (kx == '0) && (ky == '0);
   assign rd_last  = rd_valid && k_last;

   // Output position is tracked for window termination only; the write
   // address comes from a running pointer instead.
   assign unused_pos = ^{ox, oy};

   conv2d_win_counter #(.W(DIM_WIDTH)) u_kern_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .inc    (rd_fire),
      .lim_x  (k_lim_x),
      .lim_y  (k_lim_y),
      .x      (kx),
      .y      (ky),
      .x_wrap (kx_wrap),
      .last   (k_last)
   );

   conv2d_win_counter #(.W(DIM_WIDTH)) u_out_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (cnt_clr),
      .inc    (wr_fire),
      .lim_x  (o_lim_x),
      .lim_y  (o_lim_y),
      .x      (ox),
      .y      (oy),
      .x_wrap (ox_wrap),
      .last   (o_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         img_w_q    <= '0;
         img_h_q    <= '0;
         k_w_q      <= '0;
         k_h_q      <= '0;
         in_base_q  <= '0;
         out_base_q <= '0;
         line_base  <= '0;
         win_base   <= '0;
         row_ptr    <= '0;
         rd_addr    <= '0;
         rd_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  img_w_q    <= img_w;
                  img_h_q    <= img_h;
                  k_w_q      <= k_w;
                  k_h_q      <= k_h;
                  in_base_q  <= in_base;
                  out_base_q <= out_base;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (cfg_bad) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  line_base <= in_base_q;
                  win_base  <= in_base_q;
                  row_ptr   <= in_base_q;
                  rd_addr   <= in_base_q;
                  wr_addr   <= out_base_q;
                  rd_valid  <= 1'b1;
                  state     <= ST_READ;
               end
            end

            ST_READ: begin
               if (abort) begin
                  rd_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else if (rd_ready) begin
                  if (k_last) begin
                     rd_valid <= 1'b0;
                     wr_valid <= 1'b1;
                     state    <= ST_WRITE;
                  end else if (kx_wrap) begin
                     row_ptr <= next_row;
                     rd_addr <= next_row;
                  end else begin
                     rd_addr <= rd_addr + ADDR_WIDTH'(1);
                  end
               end
            end

            ST_WRITE: begin
               if (abort) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else if (wr_ready) begin
                  wr_valid <= 1'b0;
                  wr_addr  <= wr_addr + ADDR_WIDTH'(1);
                  if (o_last) begin
                     done  <= 1'b1;
                     state <= ST_FIN;
                  end else begin
                     rd_valid <= 1'b1;
                     state    <= ST_READ;
                     if (ox_wrap) begin
                        line_base <= next_line;
                        win_base  <= next_line;
                        row_ptr   <= next_line;
                        rd_addr   <= next_line;
                     end else begin
                        win_base <= next_win;
                        row_ptr  <= next_win;
                        rd_addr  <= next_win;
                     end
                  end
               end
            end

            ST_FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               rd_valid <= 1'b0;
               wr_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_seq.sv
// tb_conv2d_seq: self-checking bench for conv2d_seq. A table of jobs is run
// through a reference address model whose expected reads/writes are queued
// at job launch and popped on every DUT handshake; abort and mid-job reset
// are exercised by hand-written sequences.
module tb_conv2d_seq;

   logic        clk = 1'b0;
   logic        resetn, start, abort, rd_ready, wr_ready;
   logic [15:0] img_w, img_h, k_w, k_h;
   logic [31:0] in_base, out_base;
   logic [31:0] rd_addr, wr_addr;
   logic        rd_first, rd_last, rd_valid, wr_valid, busy, done, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic        first;
      logic        last;
   } exp_t;

   typedef struct {
      logic [15:0] iw, ih, kw, kh;
      logic [31:0] ib, ob;
      bit          bp;
      logic        exp_err;
      int          exp_cyc;
   } job_t;

   exp_t sbq[$];
   job_t jobs[10];

   conv2d_seq dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .abort    (abort),
      .img_w    (img_w),
      .img_h    (img_h),
      .k_w      (k_w),
      .k_h      (k_h),
      .in_base  (in_base),
      .out_base (out_base),
      .rd_addr  (rd_addr),
      .rd_first (rd_first),
      .rd_last  (rd_last),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .wr_addr  (wr_addr),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name,
                      input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] all_outs();
      return {rd_addr, wr_addr, 25'd0, rd_first, rd_last, rd_valid,
              wr_valid, busy, done, err};
   endfunction

   task automatic push_model(input job_t j);
      int ow, oh;
      exp_t e;
      if (j.exp_err) return;
      ow = int'(j.iw) - int'(j.kw) + 1;
      oh = int'(j.ih) - int'(j.kh) + 1;
      for (int oy = 0; oy < oh; oy++) begin
         for (int ox = 0; ox < ow; ox++) begin
            for (int ky = 0; ky < int'(j.kh); ky++) begin
               for (int kx = 0; kx < int'(j.kw); kx++) begin
                  e.is_wr = 1'b0;
                  e.addr  = j.ib + 32'((oy + ky) * int'(j.iw) + ox + kx);
                  e.first = (kx == 0) && (ky == 0);
                  e.last  = (kx == int'(j.kw) - 1) && (ky == int'(j.kh) - 1);
                  sbq.push_back(e);
               end
            end
            e.is_wr = 1'b1;
            e.addr  = j.ob + 32'(oy * ow + ox);
            e.first = 1'b0;
            e.last  = 1'b0;
            sbq.push_back(e);
         end
      end
   endtask

   task automatic drive_cfg(input job_t j);
      img_w    = j.iw;
      img_h    = j.ih;
      k_w      = j.kw;
      k_h      = j.kh;
      in_base  = j.ib;
      out_base = j.ob;
   endtask

   task automatic run_job(input job_t j);
      logic        pr_rv, pr_wv, pr_f, pr_l;
      logic [31:0] pr_ra, pr_wa;
      int          cnt;
      bit          got_done;
      exp_t        e;
      push_model(j);
      @(negedge clk);
      drive_cfg(j);
      rd_ready = 1'b1;
      wr_ready = 1'b1;
      start    = 1'b1;
      pr_rv = 1'b0; pr_wv = 1'b0; pr_f = 1'b0; pr_l = 1'b0;
      pr_ra = '0;   pr_wa = '0;
      cnt = 0;
      got_done = 1'b0;
      while (!got_done && cnt < 3000) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            start = 1'b0;
            chk(busy == 1'b1, "busy_in_check", 96'(busy), 96'(1));
         end
         chk(!(rd_valid && wr_valid), "valid_overlap",
             96'({rd_valid, wr_valid}), 96'(0));
         if (pr_rv)
            chk(rd_valid && rd_addr == pr_ra && rd_first == pr_f && rd_last == pr_l,
                "rd_stable", 96'({rd_valid, rd_first, rd_last, rd_addr}),
                96'({1'b1, pr_f, pr_l, pr_ra}));
         if (pr_wv)
            chk(wr_valid && wr_addr == pr_wa, "wr_stable",
                96'({wr_valid, wr_addr}), 96'({1'b1, pr_wa}));
         if (j.bp) begin
            rd_ready = 1'($urandom_range(0, 1));
            wr_ready = 1'($urandom_range(0, 1));
         end
         pr_rv = rd_valid && !rd_ready;
         pr_ra = rd_addr;
         pr_f  = rd_first;
         pr_l  = rd_last;
         pr_wv = wr_valid && !wr_ready;
         pr_wa = wr_addr;
         if (rd_valid && rd_ready) begin
            if (sbq.size() == 0) begin
               chk(1'b0, "rd_unexpected", 96'(rd_addr), 96'(0));
            end else begin
               e = sbq.pop_front();
               chk(!e.is_wr && rd_addr == e.addr && rd_first == e.first && rd_last == e.last,
                   "rd_seq", 96'({1'b0, rd_first, rd_last, rd_addr}),
                   96'({e.is_wr, e.first, e.last, e.addr}));
            end
         end
         if (wr_valid && wr_ready) begin
            if (sbq.size() == 0) begin
               chk(1'b0, "wr_unexpected", 96'(wr_addr), 96'(0));
            end else begin
               e = sbq.pop_front();
               chk(e.is_wr && wr_addr == e.addr, "wr_seq",
                   96'({1'b1, wr_addr}), 96'({e.is_wr, e.addr}));
            end
         end
         if (done) got_done = 1'b1;
      end
      chk(got_done, "done_timeout", 96'(cnt), 96'(j.exp_cyc));
      if (got_done) begin
         chk(err == j.exp_err, "err_at_done", 96'(err), 96'(j.exp_err));
         if (j.exp_cyc != 0)
            chk(cnt == j.exp_cyc, "start_to_done", 96'(cnt), 96'(j.exp_cyc));
      end
      chk(sbq.size() == 0, "sb_leftover", 96'(sbq.size()), 96'(0));
      sbq.delete();
      @(negedge clk);
      chk(!busy && !done && err == j.exp_err, "idle_after_done",
          96'({busy, done, err}), 96'({2'b00, j.exp_err}));
      rd_ready = 1'b1;
      wr_ready = 1'b1;
   endtask

   initial begin
      bit seen_done;

      //            iw     ih     kw     kh     in_base        out_base       bp    err   cycles
      jobs[0] = '{16'd4, 16'd4, 16'd3, 16'd3, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 42};
      jobs[1] = '{16'd4, 16'd4, 16'd5, 16'd3, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 2};
      jobs[2] = '{16'd4, 16'd4, 16'd3, 16'd3, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 42};
      jobs[3] = '{16'd3, 16'd2, 16'd1, 16'd1, 32'h0000_0100, 32'h0000_0300, 1'b0, 1'b0, 14};
      jobs[4] = '{16'd5, 16'd5, 16'd3, 16'd3, 32'h0000_4000, 32'h0000_5000, 1'b1, 1'b0, 0};
      jobs[5] = '{16'd5, 16'd5, 16'd3, 16'd3, 32'h0000_4000, 32'h0000_5000, 1'b0, 1'b0, 92};
      jobs[6] = '{16'd4, 16'd4, 16'd2, 16'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0, 1'b0, 47};
      jobs[7] = '{16'd4, 16'd4, 16'd0, 16'd2, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 2};
      jobs[8] = '{16'd3, 16'd2, 16'd2, 16'd3, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 2};
      jobs[9] = '{16'd1, 16'd1, 16'd1, 16'd1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 4};

      resetn   = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      rd_ready = 1'b1;
      wr_ready = 1'b1;
      drive_cfg(jobs[0]);
      repeat (3) @(negedge clk);
      chk(all_outs() == '0, "reset_outputs", all_outs(), 96'(0));
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) run_job(jobs[i]);

      // abort in the middle of window 2 (reads of that window occupy cycles 22..30)
      @(negedge clk);
      drive_cfg(jobs[0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (24) @(negedge clk);
      chk(rd_valid == 1'b1, "pre_abort_read", 96'(rd_valid), 96'(1));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk(!rd_valid && !wr_valid && !busy && !done, "abort_to_idle",
          96'({rd_valid, wr_valid, busy, done}), 96'(0));
      seen_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk(!seen_done, "abort_no_done", 96'(seen_done), 96'(0));
      run_job(jobs[0]);

      // reset while reading
      @(negedge clk);
      drive_cfg(jobs[0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk(rd_valid == 1'b1 && busy == 1'b1, "pre_reset_read",
          96'({rd_valid, busy}), 96'(3));
      resetn = 1'b0;
      #1;
      chk(all_outs() == '0, "reset_mid_job", all_outs(), 96'(0));
      @(negedge clk);
      resetn = 1'b1;
      run_job(jobs[3]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv2d_seq.md
# conv2d_seq

Address sequencer for the conv2d accelerator. It latches an image/kernel configuration on `start` and walks every valid (no-padding) output position. For each position it issues one read address per kernel tap to the MAC datapath, then one write address for the finished result. It sits between the control register block and the convolution datapath/memory port, and produces the `busy`/`done` status that the control block reports.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of image memory.
- `DIM_WIDTH`, 16: width of every dimension field and counter.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the running job.
- `img_w`, `img_h` in DIM_WIDTH: image size in pixels (1 byte/pixel).
- `k_w`, `k_h` in DIM_WIDTH: kernel size.
- `in_base`, `out_base` in ADDR_WIDTH: image and result base addresses.
- `rd_addr` out ADDR_WIDTH: tap read address.
- `rd_first`, `rd_last` out 1: first/last tap of current window.
- `rd_valid` out 1 / `rd_ready` in 1: read handshake.
- `wr_addr` out ADDR_WIDTH: result address for the completed window.
- `wr_valid` out 1 / `wr_ready` in 1: write handshake.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle end-of-job pulse.
- `err` out 1: config error flag, valid with `done`, held until next `start`.

## Operation
- States: IDLE, CHECK, READ, WRITE, FIN.
- IDLE: `start`=1 latches all config inputs and clears `err`; next state is CHECK. `start` is ignored in every other state.
- CHECK: if `k_w`==0, `k_h`==0, `k_w`>`img_w` or `k_h`>`img_h`, set `err` and go to FIN; otherwise go to READ. `img_w`=0 or `img_h`=0 is covered by these checks.
- Output size: out_w = img_w-k_w+1, out_h = img_h-k_h+1.
- READ: rd_addr = in_base + (oy+ky)·img_w + (ox+kx), with kx innermost, then ky.
  - Row pointers are updated by adding img_w, so no multiplier is used.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not an error.
  - rd_first = (kx==0 && ky==0); rd_last = (kx==k_w-1 && ky==k_h-1).
  - After the rd_last handshake, go to WRITE.
- WRITE: wr_addr = out_base + oy·out_w + ox, where the output offset is a running counter. After the handshake:
  - advance ox, then oy;
  - go back to READ, or to FIN after the last window.
- FIN: `done`=1 for one cycle, then IDLE.
- `abort`=1 in CHECK/READ/WRITE: go to IDLE next cycle, drop valids, no `done` pulse. `abort` in IDLE or FIN has no effect.
- `busy`=1 in CHECK, READ, WRITE and FIN.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-job: immediate return to IDLE with outputs 0. No `done` pulse.
- `start` high in cycle N → CHECK in N+1 → first `rd_valid` in N+2.
- `rd_valid`/`wr_valid` hold and their address/flag outputs stay stable until the matching ready is seen. Valid never drops without a handshake, except on abort or reset.
- With both readies held high, throughput is one tap per cycle. Each window takes k_w·k_h+1 cycles.
- Total time from `start` to `done` with readies high: 2 + out_w·out_h·(k_w·k_h+1) cycles.
- Error path: `done` and `err` are asserted in cycle N+2.
- `rd_valid` and `wr_valid` are never high in the same cycle.

## Structure
- `conv2d_pkg`: state enum and the DIM_WIDTH/ADDR_WIDTH default constants.
- Sub-module `conv2d_win_counter`: 2-D counter with limits (lim_x, lim_y), inc, clr and outputs x, y, x_wrap, last.
  - One instance walks the kernel (kx, ky).
  - One instance walks the output (ox, oy).

## Test plan
- img 4×4, k 3×3, in_base 0x1000, out_base 0x2000, readies high:
  - window 0 reads 0x1000,01,02,04,05,06,08,09,0A;
  - writes go to 0x2000..0x2003;
  - `done` arrives 42 cycles after `start`.
- k_w=5, img_w=4: no `rd_valid`, `done`=`err`=1 two cycles after `start`; a following valid `start` clears `err`.
- img 3×2, k 1×1: six reads with rd_first=rd_last=1 and six writes in order.
- Random `rd_ready`/`wr_ready` backpressure on 5×5/3×3: the address sequence matches the ready-high run and outputs stay stable while stalled.
- `abort` during window 2 of the 4×4 case: idle next cycle, no `done`; a fresh `start` restarts from 0x1000.
- `resetn` low mid-READ: all outputs 0 immediately; after release the block accepts `start`.
- Base 0xFFFF_FFFE, img 4×4, k 2×2: addresses wrap to 0x0000_0000 with no error.
